usr_ctrl: RTL and testbench
===========================

USR_CTRL -- requirements
Module: usr_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: clear  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid  input  1  command offered.
REQ-004 SHALL have ports: cmd_ready  output  1  queue can accept; high when fewer than 2 entries are queued.
REQ-005 SHALL have ports: cmd_op  input  3  mode code to issue.
REQ-006 SHALL have ports: cmd_cnt  input  4  number of cycles to issue the mode; 0 means 16.
REQ-007 SHALL have ports: cmd_data  input  4  parallel-load word.
REQ-008 SHALL have ports: S  output  3  registered mode select to the 4-bit universal shift register.
REQ-009 SHALL have ports: I  output  4  registered parallel data to the register.
REQ-010 SHALL have ports: busy  output  1  high while a command is being issued.
REQ-011 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: done_cnt  output  8  count of completed commands.

Function
REQ-013 SHALL use the mode encoding: 000 hold, 001 shift toward MSB with 0 in, 010 shift toward LSB with 0 in, 011 parallel load, 100 complement, 101 rotate toward MSB, 110 rotate toward LSB, 111 rotate by two.
REQ-014 SHALL accept a command at a rising edge where cmd_valid and cmd_ready are both high, storing {op, cnt, data} in a 2-entry FIFO.
REQ-015 SHALL have two states: IDLE (S=000, busy=0) and RUN (S=current op, busy=1).
REQ-016 In IDLE with a non-empty queue at an edge, SHALL pop the head, load S=op, I=data, remaining=cnt (0 becomes 16), and enter RUN.
REQ-017 SHALL hold S and I constant for exactly `remaining` cycles in RUN, decrementing remaining once per edge.
REQ-018 At the edge ending the final RUN cycle, SHALL pop and start the next queued command with no gap if one was queued before that edge; otherwise SHALL set S=000 and return to IDLE.
REQ-019 SHALL assert done for exactly one cycle following each command's final RUN cycle, including back-to-back completions.
REQ-020 SHALL increment done_cnt once per done pulse, wrapping 255 to 0.
REQ-021 SHALL give one-cycle latency from acceptance into an empty IDLE queue to the first RUN cycle.
REQ-022 SHALL hold I at its last loaded value when S is not 011.
REQ-023 A push into the queue and a pop from it on the same edge SHALL both take effect, with the entry count unchanged.
REQ-024 cmd_ready SHALL be driven only from registered count; it SHALL NOT combinationally depend on cmd_valid.

Reset
REQ-025 While clear is low, regardless of clk: S=000, I=0000, busy=0, done=0, done_cnt=0, queue empty, cmd_ready=1, state IDLE.
REQ-026 Reset asserted during RUN SHALL discard the executing and queued commands and SHALL NOT produce a done pulse.
REQ-027 After clear rises, the first command SHALL be accepted at the first qualifying edge.

Configuration
REQ-028 With macro USR_CTRL_ABORT_EN defined, SHALL add an input port abort (1 bit); abort high at an edge empties the queue, forces S=000 and IDLE, and produces no done pulse, with abort taking priority over acceptance that edge.
REQ-029 Without USR_CTRL_ABORT_EN, SHALL have no abort port and commands SHALL always run to completion.

Verification
REQ-030 Reset then push {011, cnt 1, 1001}: S=011, I=1001 for exactly 1 cycle, then S=000, done pulses once, done_cnt=1.
REQ-031 Push {010, cnt 3} then {101, cnt 2} back-to-back: S=010 for 3 cycles, then 101 for 2 cycles with no 000 gap; two done pulses; done_cnt=2.
REQ-032 Hold cmd_valid high with a long command running: cmd_ready drops after 2 accepts and rises the cycle after the pop.
REQ-033 Push cmd_cnt=0 with op 100: S=100 for 16 cycles.
REQ-034 Drop clear mid-RUN with 1 entry queued: outputs at reset values immediately, no done pulse, cmd_ready=1.
REQ-035 Run 256 commands of cnt 1: done_cnt wraps to 0; with USR_CTRL_ABORT_EN, abort mid-RUN gives S=000 next cycle and an empty queue.

Source files
------------

// File: rtl/usr_ctrl.sv
// Command sequencer for a 4-bit universal shift register: 2-entry command FIFO feeding an IDLE/RUN issuer.
// Optional USR_CTRL_ABORT_EN adds an abort input that flushes the queue and returns to IDLE.
module usr_ctrl (
    input  logic       clk,
    input  logic       clear,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_cnt,
    input  logic [3:0] cmd_data,
`ifdef USR_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] S,
    output logic [3:0] I,
    output logic       busy,
    output logic       done,
    output logic [7:0] done_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [2:0] r_q_op   [2];
    logic [3:0] r_q_cnt  [2];
    logic [3:0] r_q_data [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic [4:0] r_remaining;
    logic [2:0] r_s;
    logic [3:0] r_i;
    logic       r_done;
    logic [7:0] r_done_cnt;

    logic       w_abort;
    logic       w_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_last;
    logic [4:0] w_head_cnt;

`ifdef USR_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Ready comes only from the registered occupancy, never from cmd_valid.
    assign w_ready    = (r_count != 2'd2);
    assign w_push     = cmd_valid & w_ready & ~w_abort;
    assign w_last     = (r_state == ST_RUN) && (r_remaining == 5'd1);
    assign w_pop      = ~w_abort && (r_count != 2'd0) && ((r_state == ST_IDLE) || w_last);
    assign w_head_cnt = (r_q_cnt[r_rd_ptr] == 4'd0) ? 5'd16 : {1'b0, r_q_cnt[r_rd_ptr]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wr_ptr]   <= cmd_op;
            r_q_cnt[r_wr_ptr]  <= cmd_cnt;
            r_q_data[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_remaining <= 5'd0;
            r_s         <= 3'b000;
            r_i         <= 4'b0000;
            r_done      <= 1'b0;
            r_done_cnt  <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Abort drops everything in flight and suppresses the completion pulse.
                r_state     <= ST_IDLE;
                r_wr_ptr    <= 1'b0;
                r_rd_ptr    <= 1'b0;
                r_count     <= 2'd0;
                r_remaining <= 5'd0;
                r_s         <= 3'b000;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase

                if (w_last) begin
                    r_done     <= 1'b1;
                    r_done_cnt <= r_done_cnt + 8'd1;
                end

                // A queued command starts on the same edge the previous one ends.
                if (w_pop) begin
                    r_state     <= ST_RUN;
                    r_s         <= r_q_op[r_rd_ptr];
                    r_i         <= r_q_data[r_rd_ptr];
                    r_remaining <= w_head_cnt;
                end else if (w_last) begin
                    r_state     <= ST_IDLE;
                    r_s         <= 3'b000;
                    r_remaining <= 5'd0;
                end else if (r_state == ST_RUN) begin
                    r_remaining <= r_remaining - 5'd1;
                end
            end
        end
    end

    assign cmd_ready = w_ready;
    assign S         = r_s;
    assign I         = r_i;
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl: per-cycle scoreboard of expected S/I/done/done_cnt fed by pushed commands.
module tb_usr_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic [3:0] cmd_data = 4'd0;
`ifdef USR_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       cmd_ready;
    logic [2:0] S;
    logic [3:0] I;
    logic       busy;
    logic       done;
    logic [7:0] done_cnt;

    always #5 clk = ~clk;

    usr_ctrl dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
`ifdef USR_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .S         (S),
        .I         (I),
        .busy      (busy),
        .done      (done),
        .done_cnt  (done_cnt)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic       prev_last = 1'b0;
    logic [7:0] exp_dcnt = 8'd0;
    logic [3:0] last_i = 4'd0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic exp_done;
        exp_t e;
        exp_done  = prev_last;
        prev_last = 1'b0;
        if (exp_done) exp_dcnt = exp_dcnt + 8'd1;
        if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("busy_unexpected", {31'd0, busy}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("S_run", {29'd0, S}, {29'd0, e.op});
                chk("I_run", {28'd0, I}, {28'd0, e.data});
                last_i    = e.data;
                prev_last = e.last;
            end
        end else begin
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("S_idle", {29'd0, S}, 32'd0);
            chk("I_hold", {28'd0, I}, {28'd0, last_i});
        end
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("done_cnt", {24'd0, done_cnt}, {24'd0, exp_dcnt});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic flush_all();
        exp_q.delete();
        prev_last = 1'b0;
        exp_dcnt  = 8'd0;
        last_i    = 4'd0;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] data);
        int n;
        n = (cnt == 4'd0) ? 16 : int'(cnt);
        for (int k = 0; k < n; k++) exp_q.push_back('{op: op, data: data, last: (k == n - 1)});
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] data);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
        push_exp(op, cnt, data);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 400) begin
            cyc();
            n++;
        end
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         n;
        logic [2:0] prev_s;
        logic [7:0] base;

        // Asynchronous reset, checked before any clock edge
        #2 clear = 1'b0;
        #2;
        flush_all();
        chk("rst_S", {29'd0, S}, 32'd0);
        chk("rst_I", {28'd0, I}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_cnt", {24'd0, done_cnt}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cyc();
        @(negedge clk);
        clear = 1'b1;

        // Single parallel load, accepted at the first edge after reset release
        push(3'b011, 4'd1, 4'b1001);
        chk("lat_idle", {31'd0, busy}, 32'd0);
        cyc();
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("load_S", {29'd0, S}, 32'd3);
        chk("load_I", {28'd0, I}, 32'h9);
        cyc();
        chk("load_end_busy", {31'd0, busy}, 32'd0);
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_done_cnt", {24'd0, done_cnt}, 32'd1);
        cyc();
        chk("load_I_hold", {28'd0, I}, 32'h9);

        // Back-to-back commands with no idle gap
        push(3'b010, 4'd3, 4'ha);
        push(3'b101, 4'd2, 4'h5);
        chk("b2b_busy0", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("b2b_busy", {31'd0, busy}, 32'd1);
        end
        cyc();
        chk("b2b_end_busy", {31'd0, busy}, 32'd0);
        chk("b2b_done", {31'd0, done}, 32'd1);
        drain();

        // Queue fills behind a long command; ready returns the cycle after the pop
        push(3'b001, 4'd8, 4'h3);
        cyc();
        cmd_valid = 1'b1;
        cmd_op = 3'b110; cmd_cnt = 4'd2; cmd_data = 4'h1;
        push_exp(cmd_op, cmd_cnt, cmd_data);
        cyc();
        chk("ready_one", {31'd0, cmd_ready}, 32'd1);
        cmd_op = 3'b111; cmd_cnt = 4'd3; cmd_data = 4'h2;
        push_exp(cmd_op, cmd_cnt, cmd_data);
        cyc();
        chk("ready_full", {31'd0, cmd_ready}, 32'd0);
        cmd_op = 3'b010; cmd_cnt = 4'd1; cmd_data = 4'h4;
        n = 0;
        prev_s = S;
        while (cmd_ready !== 1'b1 && n < 20) begin
            prev_s = S;
            cyc();
            n++;
        end
        chk("ready_wait", n, 32'd6);
        chk("ready_rise_S", {29'd0, S}, 32'd6);
        chk("ready_prev_S", {29'd0, prev_s}, 32'd1);
        push_exp(cmd_op, cmd_cnt, cmd_data);
        cyc();
        cmd_valid = 1'b0;
        drain();

        // cnt 0 runs for 16 cycles
        push(3'b100, 4'd0, 4'h5);
        drain();

        // Reset mid-RUN with one entry queued
        push(3'b001, 4'd8, 4'h7);
        push(3'b110, 4'd3, 4'h6);
        cyc();
        cyc();
        #2 clear = 1'b0;
        #1;
        flush_all();
        chk("midrst_S", {29'd0, S}, 32'd0);
        chk("midrst_I", {28'd0, I}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_done_cnt", {24'd0, done_cnt}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cyc();
        @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k < 4; k++) cyc();

        // 256 single-cycle commands wrap the completion counter
        base = exp_dcnt;
        cmd_valid = 1'b1;
        cmd_op  = 3'b001;
        cmd_cnt = 4'd1;
        for (int k = 0; k < 256; k++) begin
            cmd_data = 4'(k);
            n = 0;
            while (cmd_ready !== 1'b1 && n < 20) begin
                cyc();
                n++;
            end
            if (n >= 20) chk("wrap_ready_timeout", {31'd0, cmd_ready}, 32'd1);
            push_exp(cmd_op, cmd_cnt, cmd_data);
            cyc();
        end
        cmd_valid = 1'b0;
        drain();
        chk("wrap_done_cnt", {24'd0, done_cnt}, {24'd0, base});

`ifdef USR_CTRL_ABORT_EN
        // Abort mid-RUN flushes the queue and wins over a same-edge acceptance
        push(3'b101, 4'd10, 4'h2);
        push(3'b011, 4'd4, 4'h6);
        cyc();
        cyc();
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'b111; cmd_cnt = 4'd2; cmd_data = 4'hf;
        exp_q.delete();
        prev_last = 1'b0;
        cyc();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_S", {29'd0, S}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 0; k < 4; k++) cyc();
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
